// File: rtl/riscv_commit_monitor.sv
// Commit monitor: matches writeback/store traffic against programmable PASS/FAIL channels, plus timeout/hang and retire counters.
// Latency: the verdict is registered one cycle after the deciding event is sampled; it stays sticky in DONE.
// Backpressure: none; this is a passive tap and observes every input cycle.
module riscv_commit_monitor #(
    parameter int NUM_CHK    = 4,
    parameter int CW         = (NUM_CHK > 1) ? $clog2(NUM_CHK) : 1,
    parameter int HANG_LIMIT = 256
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic                   wb_valid,
    input  logic [4:0]             wb_rd,
    input  logic [31:0]            wb_data,
    input  logic [31:0]            wb_pc,
    input  logic                   st_valid,
    input  logic [31:0]            st_addr,
    input  logic [3:0]             st_be,
    input  logic [31:0]            st_data,
    input  logic [NUM_CHK-1:0]     chk_en,
    input  logic [NUM_CHK-1:0]     chk_kind,
    input  logic [NUM_CHK-1:0]     chk_is_fail,
    input  logic [NUM_CHK-1:0]     chk_use_val,
    input  logic [32*NUM_CHK-1:0]  chk_key,
    input  logic [32*NUM_CHK-1:0]  chk_val,
    input  logic [31:0]            max_cycles,
    output logic                   done,
    output logic                   pass,
    output logic                   fail,
    output logic                   timeout,
    output logic                   hang,
    output logic [CW-1:0]          hit_chan,
    output logic [31:0]            hit_pc,
    output logic [31:0]            hit_data,
    output logic [31:0]            cycle_cnt,
    output logic [31:0]            wb_cnt,
    output logic [31:0]            st_cnt
);

    localparam logic [1:0]  ST_IDLE  = 2'd0;
    localparam logic [1:0]  ST_RUN   = 2'd1;
    localparam logic [1:0]  ST_DONE  = 2'd2;
    localparam logic [31:0] HANG_LIM = 32'(HANG_LIMIT);

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic [1:0]             state_q, state_d;
    logic [NUM_CHK-1:0]     cfg_en_q, cfg_en_d;
    logic [NUM_CHK-1:0]     cfg_kind_q, cfg_kind_d;
    logic [NUM_CHK-1:0]     cfg_fail_q, cfg_fail_d;
    logic [NUM_CHK-1:0]     cfg_useval_q, cfg_useval_d;
    logic [32*NUM_CHK-1:0]  cfg_key_q, cfg_key_d;
    logic [32*NUM_CHK-1:0]  cfg_val_q, cfg_val_d;
    logic [31:0]            max_cycles_q, max_cycles_d;
    logic [NUM_CHK-1:0]     hits_q, hits_d;
    logic [31:0]            idle_q, idle_d;
    logic [31:0]            cycle_cnt_q, cycle_cnt_d;
    logic [31:0]            wb_cnt_q, wb_cnt_d;
    logic [31:0]            st_cnt_q, st_cnt_d;
    logic                   pass_q, pass_d;
    logic                   fail_q, fail_d;
    logic                   timeout_q, timeout_d;
    logic                   hang_q, hang_d;
    logic [CW-1:0]          hit_chan_q, hit_chan_d;
    logic [31:0]            hit_pc_q, hit_pc_d;
    logic [31:0]            hit_data_q, hit_data_d;

    logic [NUM_CHK-1:0]     wb_match, st_match;
    logic [NUM_CHK-1:0]     chan_hit, fail_hit, pass_hit, pass_req, hits_nxt;
    logic [31:0]            st_mask, idle_nxt;
    logic                   pass_evt, timeout_evt, hang_evt;
    logic [CW-1:0]          fail_chan, pass_chan;
    logic [31:0]            fail_data, pass_data;

    assign st_mask = {{8{st_be[3]}}, {8{st_be[2]}}, {8{st_be[1]}}, {8{st_be[0]}}};

    // Per-channel raw match against the latched configuration; WB and store paths are independent.
    always_comb begin
        wb_match = '0;
        st_match = '0;
        for (int i = 0; i < NUM_CHK; i++) begin
            wb_match[i] = wb_valid && !cfg_kind_q[i] && (wb_rd != 5'd0) &&
                          (wb_rd == cfg_key_q[32*i +: 5]) &&
                          (!cfg_useval_q[i] || (wb_data == cfg_val_q[32*i +: 32]));
            st_match[i] = st_valid && cfg_kind_q[i] && (st_be != 4'd0) &&
                          (st_addr == cfg_key_q[32*i +: 32]) &&
                          (!cfg_useval_q[i] || (((st_data ^ cfg_val_q[32*i +: 32]) & st_mask) == 32'd0));
        end
    end

    assign chan_hit    = (wb_match | st_match) & cfg_en_q;
    assign fail_hit    = chan_hit & cfg_fail_q;
    assign pass_hit    = chan_hit & ~cfg_fail_q;
    assign pass_req    = cfg_en_q & ~cfg_fail_q;
    // This cycle's hits count towards completion, so the last requirement decides immediately.
    assign hits_nxt    = hits_q | pass_hit;
    assign pass_evt    = (pass_req != '0) && ((hits_nxt & pass_req) == pass_req);
    assign timeout_evt = (max_cycles_q != 32'd0) && (cycle_cnt_q == max_cycles_q - 32'd1);
    assign idle_nxt    = (wb_valid || st_valid) ? 32'd0 : sat_inc(idle_q);
    assign hang_evt    = (HANG_LIM != 32'd0) && (idle_nxt == HANG_LIM);

    // Lowest-index deciding channel and its event data, separately for FAIL and PASS.
    always_comb begin
        fail_chan = '0;
        fail_data = '0;
        pass_chan = '0;
        pass_data = '0;
        for (int i = NUM_CHK - 1; i >= 0; i--) begin
            if (fail_hit[i]) begin
                fail_chan = CW'(i);
                fail_data = cfg_kind_q[i] ? st_data : wb_data;
            end
            if (pass_hit[i]) begin
                pass_chan = CW'(i);
                pass_data = cfg_kind_q[i] ? st_data : wb_data;
            end
        end
    end

    // FSM, config latch, counters and verdict capture.
    always_comb begin
        state_d      = state_q;
        cfg_en_d     = cfg_en_q;
        cfg_kind_d   = cfg_kind_q;
        cfg_fail_d   = cfg_fail_q;
        cfg_useval_d = cfg_useval_q;
        cfg_key_d    = cfg_key_q;
        cfg_val_d    = cfg_val_q;
        max_cycles_d = max_cycles_q;
        hits_d       = hits_q;
        idle_d       = idle_q;
        cycle_cnt_d  = cycle_cnt_q;
        wb_cnt_d     = wb_cnt_q;
        st_cnt_d     = st_cnt_q;
        pass_d       = pass_q;
        fail_d       = fail_q;
        timeout_d    = timeout_q;
        hang_d       = hang_q;
        hit_chan_d   = hit_chan_q;
        hit_pc_d     = hit_pc_q;
        hit_data_d   = hit_data_q;

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d      = ST_RUN;
                    cfg_en_d     = chk_en;
                    cfg_kind_d   = chk_kind;
                    cfg_fail_d   = chk_is_fail;
                    cfg_useval_d = chk_use_val;
                    cfg_key_d    = chk_key;
                    cfg_val_d    = chk_val;
                    max_cycles_d = max_cycles;
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else begin
                    cycle_cnt_d = sat_inc(cycle_cnt_q);
                    if (wb_valid) begin
                        wb_cnt_d = sat_inc(wb_cnt_q);
                        hit_pc_d = wb_pc;
                    end
                    if (st_valid) begin
                        st_cnt_d = sat_inc(st_cnt_q);
                    end
                    idle_d = idle_nxt;
                    hits_d = hits_nxt;
                    if (fail_hit != '0) begin
                        state_d    = ST_DONE;
                        fail_d     = 1'b1;
                        hit_chan_d = fail_chan;
                        hit_data_d = fail_data;
                    end else if (pass_evt) begin
                        state_d    = ST_DONE;
                        pass_d     = 1'b1;
                        hit_chan_d = pass_chan;
                        hit_data_d = pass_data;
                    end else if (timeout_evt) begin
                        state_d   = ST_DONE;
                        timeout_d = 1'b1;
                    end else if (hang_evt) begin
                        state_d = ST_DONE;
                        hang_d  = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Arming, aborting and leaving DONE all start from a clean slate.
        if ((state_q == ST_IDLE && enable) || (state_q != ST_IDLE && !enable)) begin
            hits_d      = '0;
            idle_d      = '0;
            cycle_cnt_d = '0;
            wb_cnt_d    = '0;
            st_cnt_d    = '0;
            pass_d      = 1'b0;
            fail_d      = 1'b0;
            timeout_d   = 1'b0;
            hang_d      = 1'b0;
            hit_chan_d  = '0;
            hit_pc_d    = '0;
            hit_data_d  = '0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cfg_en_q     <= '0;
            cfg_kind_q   <= '0;
            cfg_fail_q   <= '0;
            cfg_useval_q <= '0;
            cfg_key_q    <= '0;
            cfg_val_q    <= '0;
            max_cycles_q <= '0;
            hits_q       <= '0;
            idle_q       <= '0;
            cycle_cnt_q  <= '0;
            wb_cnt_q     <= '0;
            st_cnt_q     <= '0;
            pass_q       <= 1'b0;
            fail_q       <= 1'b0;
            timeout_q    <= 1'b0;
            hang_q       <= 1'b0;
            hit_chan_q   <= '0;
            hit_pc_q     <= '0;
            hit_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            cfg_en_q     <= cfg_en_d;
            cfg_kind_q   <= cfg_kind_d;
            cfg_fail_q   <= cfg_fail_d;
            cfg_useval_q <= cfg_useval_d;
            cfg_key_q    <= cfg_key_d;
            cfg_val_q    <= cfg_val_d;
            max_cycles_q <= max_cycles_d;
            hits_q       <= hits_d;
            idle_q       <= idle_d;
            cycle_cnt_q  <= cycle_cnt_d;
            wb_cnt_q     <= wb_cnt_d;
            st_cnt_q     <= st_cnt_d;
            pass_q       <= pass_d;
            fail_q       <= fail_d;
            timeout_q    <= timeout_d;
            hang_q       <= hang_d;
            hit_chan_q   <= hit_chan_d;
            hit_pc_q     <= hit_pc_d;
            hit_data_q   <= hit_data_d;
        end
    end

    assign done      = (state_q == ST_DONE);
    assign pass      = pass_q;
    assign fail      = fail_q;
    assign timeout   = timeout_q;
    assign hang      = hang_q;
    assign hit_chan  = done ? hit_chan_q : '0;
    assign hit_pc    = done ? hit_pc_q : 32'd0;
    assign hit_data  = done ? hit_data_q : 32'd0;
    assign cycle_cnt = cycle_cnt_q;
    assign wb_cnt    = wb_cnt_q;
    assign st_cnt    = st_cnt_q;

endmodule

// File: tb/tb_riscv_commit_monitor.sv
// Bench for riscv_commit_monitor: directed scenarios plus randomized ones against a cycle-walking reference model.
// Latency: expected verdicts are queued at issue time and popped when done rises.
// Backpressure: none; the DUT is a passive tap.
module tb_riscv_commit_monitor;

    localparam int N    = 4;
    localparam int HL   = 16;
    localparam int MAXE = 64;

    typedef struct {
        logic [3:0]  vrd;   // {pass, fail, timeout, hang}
        int          chan;
        logic [31:0] pc;
        logic [31:0] data;
        logic [31:0] cyc;
        logic [31:0] wbc;
        logic [31:0] stc;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              enable = 1'b0;
    logic              wb_valid = 1'b0;
    logic [4:0]        wb_rd = '0;
    logic [31:0]       wb_data = '0;
    logic [31:0]       wb_pc = '0;
    logic              st_valid = 1'b0;
    logic [31:0]       st_addr = '0;
    logic [3:0]        st_be = '0;
    logic [31:0]       st_data = '0;
    logic [N-1:0]      chk_en = '0;
    logic [N-1:0]      chk_kind = '0;
    logic [N-1:0]      chk_is_fail = '0;
    logic [N-1:0]      chk_use_val = '0;
    logic [32*N-1:0]   chk_key = '0;
    logic [32*N-1:0]   chk_val = '0;
    logic [31:0]       max_cycles = '0;
    logic              done, pass, fail, timeout, hang;
    logic [1:0]        hit_chan;
    logic [31:0]       hit_pc, hit_data, cycle_cnt, wb_cnt, st_cnt;

    riscv_commit_monitor #(.NUM_CHK(N), .CW(2), .HANG_LIMIT(HL)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_pc(wb_pc),
        .st_valid(st_valid), .st_addr(st_addr), .st_be(st_be), .st_data(st_data),
        .chk_en(chk_en), .chk_kind(chk_kind), .chk_is_fail(chk_is_fail), .chk_use_val(chk_use_val),
        .chk_key(chk_key), .chk_val(chk_val), .max_cycles(max_cycles),
        .done(done), .pass(pass), .fail(fail), .timeout(timeout), .hang(hang),
        .hit_chan(hit_chan), .hit_pc(hit_pc), .hit_data(hit_data),
        .cycle_cnt(cycle_cnt), .wb_cnt(wb_cnt), .st_cnt(st_cnt)
    );

    always #5 clk = ~clk;

    // Scenario description: channel config plus a per-cycle event list (idle after the list ends).
    logic [N-1:0] c_en, c_kind, c_fail, c_uv;
    logic [31:0]  c_key [N];
    logic [31:0]  c_val [N];
    logic [31:0]  c_max;
    int           n_ev;
    logic         e_wbv [MAXE];
    logic [4:0]   e_rd  [MAXE];
    logic [31:0]  e_wbd [MAXE];
    logic [31:0]  e_pc  [MAXE];
    logic         e_stv [MAXE];
    logic [31:0]  e_addr[MAXE];
    logic [3:0]   e_be  [MAXE];
    logic [31:0]  e_std [MAXE];

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_chk = 0;
    int   n_fail = 0;
    logic done_seen = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic check_zero(input string name);
        chk(name, {27'd0, done, pass, fail, timeout, hang}, 32'd0);
        chk({name, "_cnt"}, hit_pc | hit_data | cycle_cnt | wb_cnt | st_cnt | {30'd0, hit_chan}, 32'd0);
    endtask

    // Reference channel match: byte-by-byte comparison of the enabled store lanes.
    function automatic bit ch_match(input int i, input logic wv, input logic [4:0] rd, input logic [31:0] wd,
                                    input logic sv, input logic [31:0] a, input logic [3:0] be, input logic [31:0] sd);
        logic [31:0] k;
        logic [31:0] v;
        k = c_key[i];
        v = c_val[i];
        if (!c_kind[i]) return wv && (rd != 0) && (rd == k[4:0]) && (!c_uv[i] || wd == v);
        if (!sv || be == 0 || a != k) return 0;
        if (c_uv[i])
            for (int b = 0; b < 4; b++)
                if (be[b] && sd[8*b +: 8] != v[8*b +: 8]) return 0;
        return 1;
    endfunction

    // Reference model: walk the RUN cycles one by one until the first verdict.
    function automatic exp_t model();
        exp_t r;
        logic [N-1:0] hits, req;
        int idle, wbc, stc, fch, pch;
        logic [31:0] lastpc, fdat, pdat, wd, pc, a, sd;
        logic wv, sv;
        logic [4:0] rd;
        logic [3:0] be;
        bit m;
        r.vrd = 0; r.chan = 0; r.pc = 0; r.data = 0; r.cyc = 0; r.wbc = 0; r.stc = 0;
        hits = '0; idle = 0; wbc = 0; stc = 0; lastpc = 0;
        req = c_en & ~c_fail;
        for (int c = 0; c < 4000; c++) begin
            if (c < n_ev) begin
                wv = e_wbv[c]; rd = e_rd[c]; wd = e_wbd[c]; pc = e_pc[c];
                sv = e_stv[c]; a = e_addr[c]; be = e_be[c]; sd = e_std[c];
            end else begin
                wv = 0; rd = 0; wd = 0; pc = 0; sv = 0; a = 0; be = 0; sd = 0;
            end
            if (wv) begin lastpc = pc; wbc++; end
            if (sv) stc++;
            idle = (wv || sv) ? 0 : idle + 1;
            fch = -1; pch = -1; fdat = 0; pdat = 0;
            for (int i = 0; i < N; i++) begin
                m = c_en[i] && ch_match(i, wv, rd, wd, sv, a, be, sd);
                if (m && c_fail[i] && fch < 0) begin fch = i; fdat = c_kind[i] ? sd : wd; end
                if (m && !c_fail[i]) begin
                    hits[i] = 1'b1;
                    if (pch < 0) begin pch = i; pdat = c_kind[i] ? sd : wd; end
                end
            end
            r.cyc = 32'(c + 1); r.wbc = 32'(wbc); r.stc = 32'(stc); r.pc = lastpc;
            if (fch >= 0) begin r.vrd = 4'b0100; r.chan = fch; r.data = fdat; return r; end
            if (req != 0 && (hits & req) == req) begin r.vrd = 4'b1000; r.chan = pch; r.data = pdat; return r; end
            if (c_max != 0 && 32'(c) == c_max - 1) begin r.vrd = 4'b0010; return r; end
            if (idle == HL) begin r.vrd = 4'b0001; return r; end
        end
        return r;
    endfunction

    // Monitor: pop and compare one expected verdict each time done rises.
    always @(negedge clk) begin
        if (done && !done_seen) begin
            done_seen = 1'b1;
            if (exp_q.size() == 0) begin
                chk("unexpected_verdict", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("verdict", {28'd0, pass, fail, timeout, hang}, {28'd0, mon_e.vrd});
                chk("hit_chan", {30'd0, hit_chan}, 32'(mon_e.chan));
                chk("hit_pc", hit_pc, mon_e.pc);
                chk("hit_data", hit_data, mon_e.data);
                chk("cycle_cnt", cycle_cnt, mon_e.cyc);
                chk("wb_cnt", wb_cnt, mon_e.wbc);
                chk("st_cnt", st_cnt, mon_e.stc);
            end
        end
        if (!done) done_seen = 1'b0;
    end

    task automatic drive_idle();
        wb_valid = 0; wb_rd = 0; wb_data = 0; wb_pc = 0;
        st_valid = 0; st_addr = 0; st_be = 0; st_data = 0;
    endtask

    task automatic drive_ev(input int j);
        if (j < n_ev) begin
            wb_valid = e_wbv[j]; wb_rd = e_rd[j]; wb_data = e_wbd[j]; wb_pc = e_pc[j];
            st_valid = e_stv[j]; st_addr = e_addr[j]; st_be = e_be[j]; st_data = e_std[j];
        end else begin
            drive_idle();
        end
    endtask

    task automatic clear_scen();
        c_en = 0; c_kind = 0; c_fail = 0; c_uv = 0; c_max = 0; n_ev = 0;
        for (int i = 0; i < N; i++) begin c_key[i] = 0; c_val[i] = 0; end
    endtask

    task automatic set_ch(input int i, input logic kind, input logic isf, input logic uv,
                          input logic [31:0] key, input logic [31:0] val);
        c_en[i] = 1; c_kind[i] = kind; c_fail[i] = isf; c_uv[i] = uv; c_key[i] = key; c_val[i] = val;
    endtask

    task automatic add_ev(input logic wv, input logic [4:0] rd, input logic [31:0] wd, input logic [31:0] pc,
                          input logic sv, input logic [31:0] a, input logic [3:0] be, input logic [31:0] sd);
        e_wbv[n_ev] = wv; e_rd[n_ev] = rd; e_wbd[n_ev] = wd; e_pc[n_ev] = pc;
        e_stv[n_ev] = sv; e_addr[n_ev] = a; e_be[n_ev] = be; e_std[n_ev] = sd;
        n_ev++;
    endtask

    task automatic gen_random();
        clear_scen();
        for (int i = 0; i < N; i++) begin
            c_en[i]   = ($urandom % 4) != 0;
            c_kind[i] = 1'($urandom % 2);
            c_fail[i] = ($urandom % 4) == 0;
            c_uv[i]   = 1'($urandom % 2);
            if (!c_kind[i]) begin
                c_key[i] = $urandom_range(1, 7);
                c_val[i] = $urandom_range(1, 3);
            end else begin
                c_key[i] = 32'h1000 + 4 * $urandom_range(0, 3);
                c_val[i] = $urandom;
            end
        end
        c_max = ($urandom % 2) ? $urandom_range(10, 60) : 32'd0;
        n_ev = $urandom_range(8, 40);
        for (int j = 0; j < n_ev; j++) begin
            e_wbv[j]  = 1'($urandom % 2);
            e_rd[j]   = 5'($urandom_range(0, 7));
            e_wbd[j]  = $urandom_range(1, 3);
            e_pc[j]   = 32'h100 + 32'(4 * j);
            e_stv[j]  = ($urandom % 3) == 0;
            e_addr[j] = 32'h1000 + 4 * $urandom_range(0, 3);
            e_be[j]   = 4'($urandom % 16);
            e_std[j]  = ($urandom % 2) ? c_val[$urandom % N] : $urandom;
        end
    endtask

    // mode 0: leave DONE by dropping enable; mode 1: leave DONE via reset.
    // abort_at >= 0: drop enable before that event, expecting no verdict.
    task automatic run_scen(input int abort_at, input int mode);
        exp_t e;
        bit   got;
        e = model();
        if (abort_at < 0) exp_q.push_back(e);
        @(negedge clk);
        chk_en = c_en; chk_kind = c_kind; chk_is_fail = c_fail; chk_use_val = c_uv; max_cycles = c_max;
        for (int i = 0; i < N; i++) begin
            chk_key[32*i +: 32] = c_key[i];
            chk_val[32*i +: 32] = c_val[i];
        end
        drive_idle();
        enable = 1;
        @(posedge clk);
        got = 0;
        for (int j = 0; j < 400; j++) begin
            @(negedge clk);
            if (abort_at >= 0 && j == abort_at) begin
                chk("run_cycle_cnt", cycle_cnt, 32'(j));
                chk("run_not_done", {31'd0, done}, 32'd0);
                enable = 0;
                drive_idle();
                @(posedge clk); #1;
                check_zero("abort_clear");
                return;
            end
            drive_ev(j);
            @(posedge clk); #1;
            if (done) begin got = 1; break; end
        end
        if (!got) begin
            chk("verdict_timeout", 32'd0, 32'd1);
            if (exp_q.size() > 0) void'(exp_q.pop_back());
            enable = 0;
            return;
        end
        // Outputs must stay frozen in DONE while traffic continues.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            wb_valid = 1'($urandom % 2); wb_rd = 5'($urandom_range(1, 7)); wb_data = $urandom_range(1, 3);
            st_valid = 1'($urandom % 2); st_addr = 32'h1000; st_be = 4'hF; st_data = $urandom;
            @(posedge clk); #1;
        end
        chk("done_hold", {31'd0, done}, 32'd1);
        chk("cycle_frozen", cycle_cnt, e.cyc);
        @(negedge clk);
        drive_idle();
        if (mode == 1) rst_n = 0;
        else enable = 0;
        @(posedge clk); #1;
        check_zero(mode == 1 ? "reset_in_done" : "exit_done");
        @(negedge clk);
        rst_n = 1;
        enable = 0;
    endtask

    initial begin
        rst_n = 0;
        enable = 1;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1;
        enable = 0;

        // 1: PASS on x10 value 1, a wrong value first.
        clear_scen();
        set_ch(0, 0, 0, 1, 32'd10, 32'h1);
        add_ev(1, 5'd10, 32'h5, 32'h100, 0, 0, 0, 0);
        add_ev(1, 5'd10, 32'h1, 32'h104, 0, 0, 0, 0);
        run_scen(-1, 0);

        // 2: store alone is not enough; the later x5 write completes PASS on ch1.
        clear_scen();
        set_ch(0, 1, 0, 0, 32'h1000, 32'h0);
        set_ch(1, 0, 0, 0, 32'd5, 32'h0);
        add_ev(0, 0, 0, 0, 1, 32'h1000, 4'hF, 32'hDEAD);
        add_ev(0, 0, 0, 0, 0, 0, 0, 0);
        add_ev(0, 0, 0, 0, 0, 0, 0, 0);
        add_ev(1, 5'd5, 32'h7, 32'h200, 0, 0, 0, 0);
        run_scen(-1, 0);

        // 3: FAIL and a completing PASS in the same cycle; FAIL wins.
        clear_scen();
        set_ch(0, 1, 0, 0, 32'h2000, 32'h0);
        set_ch(2, 0, 1, 0, 32'd3, 32'h0);
        add_ev(1, 5'd3, 32'h33, 32'h300, 1, 32'h2000, 4'hF, 32'h44);
        run_scen(-1, 0);

        // 4: byte-lane masked store compare; BE=0011 misses, BE=0010 hits.
        clear_scen();
        set_ch(0, 1, 0, 1, 32'h1004, 32'h12345678);
        add_ev(0, 0, 0, 0, 1, 32'h1004, 4'b0011, 32'h00005600);
        add_ev(0, 0, 0, 0, 1, 32'h1004, 4'b0010, 32'h00005600);
        run_scen(-1, 0);

        // 5a: timeout at 50 with x0 writes keeping the hang counter clear.
        clear_scen();
        set_ch(0, 0, 0, 0, 32'd9, 32'h0);
        c_max = 50;
        for (int j = 0; j < 60; j++) add_ev(1, 5'd0, 32'h1, 32'h400 + 32'(4 * j), 0, 0, 0, 0);
        run_scen(-1, 0);

        // 5b: no traffic, timeout disabled -> hang.
        clear_scen();
        set_ch(0, 0, 0, 0, 32'd9, 32'h0);
        run_scen(-1, 0);

        // 6a: abort mid-RUN, then re-arm with scenario 1.
        clear_scen();
        set_ch(0, 0, 0, 0, 32'd9, 32'h0);
        for (int j = 0; j < 8; j++) add_ev(1, 5'd0, 32'h1, 32'h500, 0, 0, 0, 0);
        run_scen(5, 0);
        clear_scen();
        set_ch(0, 0, 0, 1, 32'd10, 32'h1);
        add_ev(1, 5'd10, 32'h1, 32'h104, 0, 0, 0, 0);
        run_scen(-1, 1);

        // 6b: re-arm after the reset in DONE.
        clear_scen();
        set_ch(1, 1, 1, 0, 32'h1008, 32'h0);
        add_ev(0, 0, 0, 0, 1, 32'h1008, 4'b0100, 32'hABCD);
        run_scen(-1, 0);

        for (int t = 0; t < 40; t++) begin
            gen_random();
            run_scen(-1, (t % 5 == 4) ? 1 : 0);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
